// File: rtl/irq_timer.sv
// Memory-mapped interval timer: TH reload, TL up-counter, TCON {ist, ien, ten}.
// A wrap of TL past all-ones reloads from TH and latches a sticky interrupt status.
module irq_timer #(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;

  logic hit_th, hit_tl, hit_tcon;
  logic ten, ien, ist;
  logic ovf;

  assign hit_th   = (Addr == BASE);
  assign hit_tl   = (Addr == BASE + 32'd4);
  assign hit_tcon = (Addr == BASE + 32'd8);

  assign ten = tcon_q[0];
  assign ien = tcon_q[1];
  assign ist = tcon_q[2];

  assign ovf = ten && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (ten) begin
      if (ovf) tl_d = th_q;
      else     tl_d = tl_q + 32'd1;
    end
    if (ovf && ien) tcon_d[2] = 1'b1;

    if (MemWr && hit_th) th_d = WriteData;
    if (MemWr && hit_tl) tl_d = WriteData;
    // A software clear racing an overflow must not lose the interrupt.
    if (MemWr && hit_tcon) begin
      tcon_d = WriteData[2:0];
      if (ovf && (ien || WriteData[1])) tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'b000;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (MemRd) begin
      if (hit_th)        ReadData = th_q;
      else if (hit_tl)   ReadData = tl_q;
      else if (hit_tcon) ReadData = {29'd0, tcon_q};
    end
  end

  assign IRQ = ist & ien;

endmodule

// File: tb/tb_irq_timer.sv
// Directed-vector bench for irq_timer: reset, periodic interrupt, clear race,
// masked count, TL write priority, TH-on-reload and address decode.
module tb_irq_timer;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        MemWr;
  logic        MemRd;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IRQ;

  int checks;
  int failures;

  irq_timer dut (
    .clk       (clk),
    .reset     (reset),
    .Addr      (Addr),
    .MemWr     (MemWr),
    .MemRd     (MemRd),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .IRQ       (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    WriteData = d;
    MemWr = 1'b1;
    @(posedge clk);
    #1;
    MemWr = 1'b0;
    Addr = 32'd0;
    WriteData = 32'd0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    MemRd = 1'b1;
    #1;
    d = ReadData;
    MemRd = 1'b0;
    Addr = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    // Held in reset since time 0.
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd0) begin
      $display("FAIL reset_init_tl: got %h expected %h", v, 32'd0); failures++;
    end
    @(negedge clk);
    reset = 1'b1;
    write_reg(A_TL, 32'd5);
    write_reg(A_TCON, 32'd7);
    checks++;
    if (IRQ !== 1'b1) begin
      $display("FAIL reset_pre_irq: got %b expected 1", IRQ); failures++;
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (IRQ !== 1'b0) begin
      $display("FAIL reset_async_irq: got %b expected 0", IRQ); failures++;
    end
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd0) begin
      $display("FAIL reset_async_tl: got %h expected 0", v); failures++;
    end
    read_reg(A_TH, v);
    checks++;
    if (v !== 32'd0) begin
      $display("FAIL reset_async_th: got %h expected 0", v); failures++;
    end
    read_reg(A_TCON, v);
    checks++;
    if (v !== 32'd0) begin
      $display("FAIL reset_async_tcon: got %h expected 0", v); failures++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    logic [31:0] exp_tl [4];
    exp_tl[0] = 32'hFFFF_FFFD;
    exp_tl[1] = 32'hFFFF_FFFE;
    exp_tl[2] = 32'hFFFF_FFFF;
    exp_tl[3] = 32'hFFFF_FFFC;
    do_reset();
    write_reg(A_TH, 32'hFFFF_FFFC);
    write_reg(A_TL, 32'hFFFF_FFFC);
    write_reg(A_TCON, 32'd3);
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFC) begin
      $display("FAIL periodic_start_tl: got %h expected FFFFFFFC", v); failures++;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      read_reg(A_TL, v);
      checks++;
      if (v !== exp_tl[i]) begin
        $display("FAIL periodic_tl_%0d: got %h expected %h", i, v, exp_tl[i]); failures++;
      end
      checks++;
      if (IRQ !== (i == 3)) begin
        $display("FAIL periodic_irq_%0d: got %b expected %b", i, IRQ, (i == 3)); failures++;
      end
    end
    // Clear on a non-overflow edge, then the next set is 4 edges after the first.
    write_reg(A_TCON, 32'd3);
    checks++;
    if (IRQ !== 1'b0) begin
      $display("FAIL periodic_clear_irq: got %b expected 0", IRQ); failures++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (IRQ !== (i == 2)) begin
        $display("FAIL periodic_second_irq_%0d: got %b expected %b", i, IRQ, (i == 2)); failures++;
      end
    end
  endtask

  task automatic test_clear_race();
    logic [31:0] v;
    // Continues from periodic: TL=FFFFFFFC, IRQ=1.
    repeat (3) @(posedge clk);
    #1;
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin
      $display("FAIL race_pre_tl: got %h expected FFFFFFFF", v); failures++;
    end
    write_reg(A_TCON, 32'd3);
    checks++;
    if (IRQ !== 1'b1) begin
      $display("FAIL race_overflow_irq: got %b expected 1", IRQ); failures++;
    end
    read_reg(A_TCON, v);
    checks++;
    if (v !== 32'd7) begin
      $display("FAIL race_overflow_tcon: got %h expected 7", v); failures++;
    end
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFC) begin
      $display("FAIL race_reload_tl: got %h expected FFFFFFFC", v); failures++;
    end
    write_reg(A_TCON, 32'd3);
    checks++;
    if (IRQ !== 1'b0) begin
      $display("FAIL race_clear_irq: got %b expected 0", IRQ); failures++;
    end
  endtask

  task automatic test_masked_count();
    logic [31:0] v;
    do_reset();
    write_reg(A_TH, 32'd7);
    write_reg(A_TL, 32'hFFFF_FFFF);
    write_reg(A_TCON, 32'd1);
    write_reg(A_TCON, 32'd0);
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd7) begin
      $display("FAIL masked_reload_tl: got %h expected 7", v); failures++;
    end
    read_reg(A_TCON, v);
    checks++;
    if (v !== 32'd0) begin
      $display("FAIL masked_ist: got %h expected 0", v); failures++;
    end
    checks++;
    if (IRQ !== 1'b0) begin
      $display("FAIL masked_irq: got %b expected 0", IRQ); failures++;
    end
    repeat (10) @(posedge clk);
    #1;
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd7) begin
      $display("FAIL masked_hold_tl: got %h expected 7", v); failures++;
    end
  endtask

  task automatic test_tl_write_priority();
    logic [31:0] v;
    do_reset();
    write_reg(A_TL, 32'd10);
    write_reg(A_TCON, 32'd1);
    write_reg(A_TL, 32'd100);
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd100) begin
      $display("FAIL tlwr_store: got %0d expected 100", v); failures++;
    end
    @(posedge clk);
    #1;
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd101) begin
      $display("FAIL tlwr_next: got %0d expected 101", v); failures++;
    end
  endtask

  task automatic test_th_on_reload();
    logic [31:0] v;
    do_reset();
    write_reg(A_TH, 32'd5);
    write_reg(A_TL, 32'hFFFF_FFFE);
    write_reg(A_TCON, 32'd1);
    write_reg(A_TH, 32'd9);
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin
      $display("FAIL threload_pre_tl: got %h expected FFFFFFFF", v); failures++;
    end
    write_reg(A_TH, 32'd20);
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'd9) begin
      $display("FAIL threload_tl: got %0d expected 9", v); failures++;
    end
    read_reg(A_TH, v);
    checks++;
    if (v !== 32'd20) begin
      $display("FAIL threload_th: got %0d expected 20", v); failures++;
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    do_reset();
    write_reg(A_TH, 32'h11);
    write_reg(A_TL, 32'h22);
    write_reg(32'h4000_000C, 32'hFFFF_FFFF);
    write_reg(32'h4000_0001, 32'hFFFF_FFFF);
    read_reg(A_TH, v);
    checks++;
    if (v !== 32'h11) begin
      $display("FAIL decode_th: got %h expected 11", v); failures++;
    end
    read_reg(A_TL, v);
    checks++;
    if (v !== 32'h22) begin
      $display("FAIL decode_tl: got %h expected 22", v); failures++;
    end
    read_reg(A_TCON, v);
    checks++;
    if (v !== 32'h0) begin
      $display("FAIL decode_tcon: got %h expected 0", v); failures++;
    end
    Addr = A_TL;
    MemRd = 1'b0;
    #1;
    checks++;
    if (ReadData !== 32'd0) begin
      $display("FAIL decode_nord: got %h expected 0", ReadData); failures++;
    end
    read_reg(32'h4000_000C, v);
    checks++;
    if (v !== 32'd0) begin
      $display("FAIL decode_unmapped_rd: got %h expected 0", v); failures++;
    end
    write_reg(A_TCON, 32'd6);
    read_reg(A_TCON, v);
    checks++;
    if (v !== 32'h0000_0006) begin
      $display("FAIL decode_tcon6: got %h expected 00000006", v); failures++;
    end
    checks++;
    if (IRQ !== 1'b1) begin
      $display("FAIL decode_sw_set_irq: got %b expected 1", IRQ); failures++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    Addr = 32'd0;
    MemWr = 1'b0;
    MemRd = 1'b0;
    WriteData = 32'd0;
    #12;
    test_reset();
    test_periodic();
    test_clear_race();
    test_masked_count();
    test_tl_write_priority();
    test_th_on_reload();
    test_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped interval timer that is the interrupt source for the CPU's exception path. It raises `IRQ`, which the register file consumes to save the return PC into $26. Software programs it through loads and stores on the peripheral bus at 0x4000_0000–0x4000_0008, and clears it through the same bus. The block sits beside data memory in the MEM stage and is clocked on `clk` posedge.

## Interface
- `BASE`, 32'h4000_0000, byte address of TH; TL = BASE+4, TCON = BASE+8.
- `clk`  input  1  system clock; all state updates on posedge.
- `reset`  input  1  asynchronous, active-low (0 = reset asserted); clears all state immediately.
- `Addr`  input  32  bus byte address from ALU result.
- `MemWr`  input  1  store strobe; a write occurs on the posedge while high and `Addr` hits.
- `MemRd`  input  1  load strobe; gates `ReadData`.
- `WriteData`  input  32  store data.
- `ReadData`  output  32  combinational read data.
- `IRQ`  output  1  level interrupt request to CPU/register file.

## Operation
- Registers: TH[31:0] (reload value), TL[31:0] (counter), TCON[2:0]: bit0 `ten` count enable, bit1 `ien` interrupt enable, bit2 `ist` interrupt status (sticky).
- Address decode compares the full 32-bit `Addr`; only word addresses BASE, BASE+4 and BASE+8 are mapped. Writes to any other address are ignored.
- Read: `ReadData` = TH / TL / {29'b0, TCON} for a hit while `MemRd`=1; otherwise 32'b0 (unmapped, or `MemRd`=0).
- Count, when `ten`=1:
  - If TL != 32'hFFFF_FFFF: TL <= TL+1.
  - If TL == 32'hFFFF_FFFF: TL <= TH (reload, no increment). If `ien`=1, `ist` <= 1 on the same edge.
- When `ten`=0: TL holds. `ist` holds.
- `IRQ` = `ist` & `ien`. The output is combinational from registers, with no path from bus inputs.
- Store to TH: TH <= WriteData. Counting is unaffected until the next reload.
- Store to TL: TL <= WriteData. This overrides the count or reload on that edge. If TL was 32'hFFFF_FFFF on that edge with `ten`=`ien`=1, `ist` still sets.
- Store to TCON: TCON <= WriteData[2:0]. Software clears the interrupt by writing bit2=0 and sets `ist` by writing bit2=1.
- Simultaneous TCON store and overflow with `ien` (new or old) = 1: `ist` <= 1. Overflow wins, so an interrupt is never lost. Bits 0 and 1 take WriteData.
- Store to TH on the same edge as a reload: TL loads the old TH, and TH takes the new value.
- Counter width is exactly 32 bits. There is no carry out beyond the reload.

## Timing
- Reset (`reset`=0, asynchronous): TH=0, TL=0, TCON=3'b000, so `IRQ`=0 and `ReadData`=0. Release is synchronous to the next posedge; the first count occurs on the first posedge after release when `ten`=1.
- Reset mid-count: state zeroes immediately, without waiting for a clock edge. `IRQ` drops in the same delta.
- Store latency: the value is visible on `ReadData` in the cycle after the write edge.
- Load latency: 0 cycles (combinational), for the current register contents.
- Overflow to `IRQ`: `IRQ` rises on the posedge where TL==FFFF_FFFF is sampled and stays high until software clears `ist` or `ien`.
- Period with `ten`=1: (2^32 − TH) cycles between successive `ist` set edges.

## Test plan
- Reset: hold `reset`=0 mid-operation with TL=5 and TCON=3'b111 → TL, TH and TCON read 0 and `IRQ`=0 immediately, before any clock edge.
- Periodic interrupt: TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3'b011 → TL goes FFFD, FFFE, FFFF. On the 4th edge TL=FFFF_FFFC and `IRQ`=1. The next `IRQ` set edge follows 4 cycles later.
- Clear vs overflow race: with `IRQ`=1, write TCON=3'b011 on the same edge that TL==FFFF_FFFF → `ist` remains 1 and `IRQ`=1. A TCON=3'b011 write on a non-overflow edge → `IRQ`=0 in the next cycle.
- Masked count: TCON=3'b001, TL=32'hFFFF_FFFF, TH=7 → TL=7 after one edge, with `ist`=0 and `IRQ`=0. Then TCON=3'b000 → TL holds 7 for 10 cycles.
- TL write priority: `ten`=1, TL=10, store TL=100 → reads 100, then 101 on the next edge. No increment is applied to the stored value on the write edge.
- Decode: store to BASE+12 and to 32'h4000_0001 → no register changes. Load from BASE+4 with `MemRd`=0 → `ReadData`=0. Load from BASE+8 with TCON=3'b110 → `ReadData`=32'h0000_0006.
